// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: opcodes, FSM encoding, default width.
// The optional starvation guard is enabled with ALU_ARB_STARVE_GUARD_EN.
package alu_pkg;

  localparam int DEF_DATA_WIDTH = 32;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4;
  localparam logic [4:0] OP_SRA = 5'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester and response channels of the ALU arbiter, with master (client) and slave (arbiter) views.
interface alu_arbiter_if;
  import alu_pkg::*;

  // valid/ready: a transfer happens on a rising edge where both are high; the sender
  // holds its payload while valid is high and not yet accepted, and ready may depend on valid.
  logic                      req_a_valid;
  logic                      req_a_ready;
  logic [4:0]                req_a_opcode;
  logic [DEF_DATA_WIDTH-1:0] req_a_operandA;
  logic [DEF_DATA_WIDTH-1:0] req_a_operandB;
  logic [4:0]                req_a_shamt;

  logic                      req_b_valid;
  logic                      req_b_ready;
  logic [4:0]                req_b_opcode;
  logic [DEF_DATA_WIDTH-1:0] req_b_operandA;
  logic [DEF_DATA_WIDTH-1:0] req_b_operandB;
  logic [4:0]                req_b_shamt;

  logic                      resp_valid;
  logic                      resp_ready;
  logic                      resp_id;
  logic [DEF_DATA_WIDTH-1:0] resp_result;

  modport master (
    output req_a_valid, req_a_opcode, req_a_operandA, req_a_operandB, req_a_shamt,
    output req_b_valid, req_b_opcode, req_b_operandA, req_b_operandB, req_b_shamt,
    output resp_ready,
    input  req_a_ready, req_b_ready, resp_valid, resp_id, resp_result
  );

  modport slave (
    input  req_a_valid, req_a_opcode, req_a_operandA, req_a_operandB, req_a_shamt,
    input  req_b_valid, req_b_opcode, req_b_operandA, req_b_operandB, req_b_shamt,
    input  resp_ready,
    output req_a_ready, req_b_ready, resp_valid, resp_id, resp_result
  );

endinterface

// File: rtl/alu_arb_grant.sv
// Combinational A/B grant: round-robin or fixed priority, with a starvation force override.
module alu_arb_grant #(
  parameter int PRIO_MODE = 0
) (
  input  logic valid_a,
  input  logic valid_b,
  input  logic ptr_b,
  input  logic force_a,
  input  logic force_b,
  output logic grant_a,
  output logic grant_b
);

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (valid_a && valid_b) begin
      // A forced requester beats the configured policy.
      if (force_a)             grant_a = 1'b1;
      else if (force_b)        grant_b = 1'b1;
      else if (PRIO_MODE == 1) grant_a = 1'b1;
      else if (ptr_b)          grant_b = 1'b1;
      else                     grant_a = 1'b1;
    end else begin
      grant_a = valid_a;
      grant_b = valid_b;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between requesters A and B; one operation in flight.
// Define ALU_ARB_STARVE_GUARD_EN to add per-requester wait counters that force a grant at 7.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PRIO_MODE  = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  alu_arbiter_if.slave          bus,
  output logic [4:0]            alu_opcode,
  output logic [DATA_WIDTH-1:0] alu_operandA,
  output logic [DATA_WIDTH-1:0] alu_operandB,
  output logic [4:0]            alu_shamt,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic [CNT_WIDTH-1:0]  ops_done,
  output state_t                state_dbg
);

  state_t state;
  logic   ptr_b;
  logic   grant_a, grant_b;
  logic   force_a, force_b;
  logic   ready_a, ready_b;

  alu_arb_grant #(.PRIO_MODE(PRIO_MODE)) u_grant (
    .valid_a (bus.req_a_valid),
    .valid_b (bus.req_b_valid),
    .ptr_b   (ptr_b),
    .force_a (force_a),
    .force_b (force_b),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  assign ready_a         = (state == IDLE) && grant_a;
  assign ready_b         = (state == IDLE) && grant_b;
  assign bus.req_a_ready = ready_a;
  assign bus.req_b_ready = ready_b;
  assign state_dbg       = state;

`ifdef ALU_ARB_STARVE_GUARD_EN
  logic [2:0] wait_a, wait_b;

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_a <= 3'd0;
      wait_b <= 3'd0;
    end else if (state == IDLE) begin
      if (ready_a)                              wait_a <= 3'd0;
      else if (bus.req_a_valid && wait_a != 3'd7) wait_a <= wait_a + 3'd1;
      if (ready_b)                              wait_b <= 3'd0;
      else if (bus.req_b_valid && wait_b != 3'd7) wait_b <= wait_b + 3'd1;
    end
  end

  assign force_a = (wait_a == 3'd7);
  assign force_b = (wait_b == 3'd7);
`else
  assign force_a = 1'b0;
  assign force_b = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      ptr_b           <= 1'b0;
      alu_opcode      <= '0;
      alu_operandA    <= '0;
      alu_operandB    <= '0;
      alu_shamt       <= '0;
      bus.resp_valid  <= 1'b0;
      bus.resp_id     <= 1'b0;
      bus.resp_result <= '0;
      ops_done        <= '0;
    end else begin
      case (state)
        IDLE: begin
          // ALU registers only load on a grant, so they hold quietly between operations.
          if (ready_a) begin
            alu_opcode   <= bus.req_a_opcode;
            alu_operandA <= bus.req_a_operandA;
            alu_operandB <= bus.req_a_operandB;
            alu_shamt    <= bus.req_a_shamt;
            bus.resp_id  <= 1'b0;
            state        <= EXEC;
          end else if (ready_b) begin
            alu_opcode   <= bus.req_b_opcode;
            alu_operandA <= bus.req_b_operandA;
            alu_operandB <= bus.req_b_operandB;
            alu_shamt    <= bus.req_b_shamt;
            bus.resp_id  <= 1'b1;
            state        <= EXEC;
          end
        end
        EXEC: begin
          bus.resp_result <= alu_result;
          bus.resp_valid  <= 1'b1;
          state           <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            ops_done       <= ops_done + 1'b1;
            if (PRIO_MODE == 0) ptr_b <= ~bus.resp_id;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
